ubus_rr_arbiter: RTL

UBUS_RR_ARBITER -- requirements
Module: ubus_rr_arbiter

---
 rtl/ubus_arb_pkg.sv | 19 +
 rtl/ubus_rr_pick.sv | 32 +++
 rtl/ubus_rr_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/ubus_arb_pkg.sv
// Shared definitions for the UBUS round-robin arbiter: FSM state encoding
// and the default sizing constants used by the arbiter and its picker.
package ubus_arb_pkg;

    typedef enum logic [2:0] {
        ST_RST   = 3'd0,
        ST_START = 3'd1,
        ST_NOOP  = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DATA  = 3'd4
    } arb_state_t;

    localparam int DEF_NUM_MASTERS  = 4;
    localparam int DEF_DATA_TIMEOUT = 16;

    // Wide enough for the largest legal DATA_TIMEOUT (255).
    localparam int CNT_W = 8;

endpackage

// File: rtl/ubus_rr_pick.sv
// Combinational round-robin winner selection: first requester strictly
// after the last owner, wrapping from NUM_MASTERS-1 back to master 0.
module ubus_rr_pick #(
    parameter  int NUM_MASTERS = 4,
    localparam int IW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IW-1:0]          i_last,
    output logic [NUM_MASTERS-1:0] o_gnt,
    output logic [IW-1:0]          o_idx,
    output logic                   o_any
);

    int w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = 0;
        // Scan offsets 1..N so the last owner itself is considered last.
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_cand = (int'(i_last) + i) % NUM_MASTERS;
            if (!o_any && i_req[w_cand[IW-1:0]]) begin
                o_any                  = 1'b1;
                o_idx                  = w_cand[IW-1:0];
                o_gnt[w_cand[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ubus_rr_arbiter.sv
// UBUS bus arbiter: START/NOOP/ADDR/DATA phase sequencing, round-robin grant,
// and a data-phase watchdog that forces the bus back to arbitration.
module ubus_rr_arbiter
    import ubus_arb_pkg::*;
#(
    parameter  int NUM_MASTERS  = DEF_NUM_MASTERS,
    parameter  int DATA_TIMEOUT = DEF_DATA_TIMEOUT,
    localparam int IW           = $clog2(NUM_MASTERS)
) (
    input  logic                   ubus_clock,
    input  logic                   ubus_reset,
    input  logic [NUM_MASTERS-1:0] ubus_req,
    output logic [NUM_MASTERS-1:0] ubus_gnt,
    output logic                   ubus_start,
    input  logic                   ubus_bip,
    input  logic                   ubus_wait,
    input  logic                   ubus_error,
    output logic                   ubus_read,
    output logic                   ubus_write,
    output logic [IW-1:0]          arb_owner,
    output logic                   arb_owner_vld,
    output logic                   arb_timeout,
    output logic [2:0]             o_dbg_state
);

    // Handshake: ubus_req is sampled only on the edge that ends START; the
    // winner sees ubus_gnt for exactly the ADDR cycle and owns the bus until
    // DATA exits. Requests that change at any other time have no effect.

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic [IW-1:0]          r_owner;
    logic [IW-1:0]          r_last;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_timeout;
    logic                   w_timeout_hit;
    logic                   w_noop;
    logic [NUM_MASTERS-1:0] w_pick_gnt;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_pick_any;

    ubus_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .i_req  (ubus_req),
        .i_last (r_last),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    always_ff @(posedge ubus_clock or posedge ubus_reset) begin
        if (ubus_reset) r_state <= ST_RST;
        else            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_RST:   w_next_state = ST_START;
            ST_START: w_next_state = w_pick_any ? ST_ADDR : ST_NOOP;
            ST_NOOP:  w_next_state = ST_START;
            ST_ADDR:  w_next_state = ST_DATA;
            ST_DATA: begin
                // A normal exit on the last allowed cycle is not a timeout.
                if (ubus_error || (!ubus_bip && !ubus_wait)) begin
                    w_next_state = ST_START;
                end else if (r_cnt == CNT_W'(DATA_TIMEOUT)) begin
                    w_next_state  = ST_START;
                    w_timeout_hit = 1'b1;
                end
            end
            default:  w_next_state = ST_RST;
        endcase
    end

    always_comb begin
        ubus_start    = (r_state == ST_START);
        arb_owner_vld = (r_state == ST_ADDR) || (r_state == ST_DATA);
        w_noop        = (r_state == ST_NOOP);
    end

    always_ff @(posedge ubus_clock or posedge ubus_reset) begin
        if (ubus_reset) begin
            r_gnt     <= '0;
            r_owner   <= '0;
            r_last    <= IW'(NUM_MASTERS - 1);
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
            case (r_state)
                ST_START: begin
                    if (w_pick_any) begin
                        r_gnt   <= w_pick_gnt;
                        r_owner <= w_pick_idx;
                        r_last  <= w_pick_idx;
                    end
                end
                ST_ADDR: begin
                    r_gnt <= '0;
                    r_cnt <= CNT_W'(1);
                end
                ST_DATA: r_cnt <= (w_next_state == ST_DATA) ? r_cnt + 1'b1 : '0;
                default: ;
            endcase
        end
    end

    assign ubus_gnt    = r_gnt;
    assign arb_owner   = r_owner;
    assign arb_timeout = r_timeout;
    assign o_dbg_state = r_state;
    assign ubus_read   = w_noop ? 1'b0 : 1'bz;
    assign ubus_write  = w_noop ? 1'b0 : 1'bz;

endmodule
